// File: rtl/my_keypad_scan.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, samples the
// synchronized rows and debounces whole sweeps into one accepted hex key.
module my_keypad_scan #(
    parameter int SCAN_W = 10,
    parameter int DEB    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key,
    output logic       key_down,
    output logic       key_valid,
    output logic       key_release
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PRESS_DB = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_REL_DB   = 2'd3;

    localparam int                DCNT_W = $clog2(DEB + 1);
    localparam logic [DCNT_W-1:0] DEB_C  = DCNT_W'(DEB);
    localparam logic [DCNT_W-1:0] ONE_C  = DCNT_W'(1);

    logic [3:0]        row_s1_q, row_s2_q;
    logic [SCAN_W-1:0] cnt_q, cnt_d;
    logic [1:0]        c_q, c_d;
    logic [3:0]        col_n_q, col_n_d;
    logic [3:0]        samp_q [4];
    logic [1:0]        state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d, dcnt_inc;
    logic [3:0]        cand_q, cand_d;
    logic [3:0]        key_q, key_d;
    logic              down_q, down_d;
    logic              valid_q, valid_d;
    logic              rel_q, rel_d;

    logic              sample_now, sweep_done;
    logic [15:0]       keys_low;
    logic [4:0]        hits;
    logic              snap_valid;
    logic [3:0]        snap_code;
    logic              cand_match, key_match;

    // Column advances on the edge that takes the last sample of the current column.
    always_comb begin
        sample_now = &cnt_q;
        sweep_done = sample_now && (c_q == 2'd3);
        cnt_d      = cnt_q + SCAN_W'(1);
        c_d        = sample_now ? c_q + 2'd1 : c_q;
        col_n_d    = ~(4'b0001 << c_d);
    end

    // Column 3 is still being sampled in the completing cycle, so it comes straight from the synchronizer.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        keys_low  = '0;
        hits      = '0;
        snap_code = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                keys_low[r*4 + c] = (c == 3) ? ~row_s2_q[r] : ~samp_q[c][r];
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (keys_low[i]) begin
                hits      = hits + 5'd1;
                snap_code = 4'(i);
            end
        end
        snap_valid = (hits == 5'd1);
        cand_match = snap_valid && (snap_code == cand_q);
        key_match  = snap_valid && (snap_code == key_q);
    end

    always_comb begin
        state_d  = state_q;
        dcnt_d   = dcnt_q;
        dcnt_inc = dcnt_q + ONE_C;
        cand_d   = cand_q;
        key_d    = key_q;
        down_d   = down_q;
        valid_d  = 1'b0;
        rel_d    = 1'b0;
        if (sweep_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (snap_valid) begin
                        cand_d = snap_code;
                        dcnt_d = ONE_C;
                        if (ONE_C == DEB_C) begin
                            state_d = ST_HELD;
                            key_d   = snap_code;
                            down_d  = 1'b1;
                            valid_d = 1'b1;
                        end else begin
                            state_d = ST_PRESS_DB;
                        end
                    end
                end
                ST_PRESS_DB: begin
                    if (cand_match) begin
                        dcnt_d = dcnt_inc;
                        if (dcnt_inc == DEB_C) begin
                            state_d = ST_HELD;
                            key_d   = cand_q;
                            down_d  = 1'b1;
                            valid_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        dcnt_d  = '0;
                    end
                end
                ST_HELD: begin
                    if (!key_match) begin
                        dcnt_d = ONE_C;
                        if (ONE_C == DEB_C) begin
                            state_d = ST_IDLE;
                            down_d  = 1'b0;
                            rel_d   = 1'b1;
                        end else begin
                            state_d = ST_REL_DB;
                        end
                    end
                end
                ST_REL_DB: begin
                    if (key_match) begin
                        state_d = ST_HELD;
                    end else begin
                        dcnt_d = dcnt_inc;
                        if (dcnt_inc == DEB_C) begin
                            state_d = ST_IDLE;
                            down_d  = 1'b0;
                            rel_d   = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
            cnt_q    <= '0;
            c_q      <= '0;
            col_n_q  <= 4'hE;
            // NOTE: the sample store is only four nibbles, so it is reset outright like any register.
            for (int i = 0; i < 4; i++) samp_q[i] <= 4'hF;
            state_q  <= ST_IDLE;
            dcnt_q   <= '0;
            cand_q   <= '0;
            key_q    <= '0;
            down_q   <= 1'b0;
            valid_q  <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            row_s1_q <= row_n;
            row_s2_q <= row_s1_q;
            if (!en) begin
                cnt_q   <= '0;
                c_q     <= '0;
                col_n_q <= 4'hF;
                state_q <= ST_IDLE;
                dcnt_q  <= '0;
                down_q  <= 1'b0;
                valid_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                c_q     <= c_d;
                col_n_q <= col_n_d;
                if (sample_now) samp_q[c_q] <= row_s2_q;
                state_q <= state_d;
                dcnt_q  <= dcnt_d;
                cand_q  <= cand_d;
                key_q   <= key_d;
                down_q  <= down_d;
                valid_q <= valid_d;
                rel_q   <= rel_d;
            end
        end
    end

    assign col_n       = col_n_q;
    assign key         = key_q;
    assign key_down    = down_q;
    assign key_valid   = valid_q;
    assign key_release = rel_q;

endmodule

// File: tb/tb_my_keypad_scan.sv
// Bench for my_keypad_scan: a keypad matrix model drives row_n from a pressed-key mask,
// and a sweep-level reference model predicts every output cycle by cycle.
module tb_my_keypad_scan;

    localparam int SCAN_W = 2;
    localparam int DEB    = 3;
    localparam int P      = 1 << SCAN_W;

    localparam logic [15:0] K9 = 16'h0200;
    localparam logic [15:0] K2 = 16'h0004;
    localparam logic [15:0] K6 = 16'h0040;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n, key;
    logic        key_down, key_valid, key_release;
    logic [15:0] mask = '0;

    int n_tests = 0;
    int n_fail  = 0;

    my_keypad_scan #(.SCAN_W(SCAN_W), .DEB(DEB)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .row_n       (row_n),
        .col_n       (col_n),
        .key         (key),
        .key_down    (key_down),
        .key_valid   (key_valid),
        .key_release (key_release)
    );

    always #5 clk = ~clk;

    // Pressed key (r,c) connects row r to column c; rows are pulled up otherwise.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (mask[r*4 + c] && (col_n[c] == 1'b0)) row_n[r] = 1'b0;
    end

    // Reference model: works in sweeps of 4 column samples, each sample seeing the
    // key mask from two cycles earlier through the synchronizer.
    logic [3:0]  exp_col = 4'hE, exp_key = 4'h0;
    logic        exp_down = 1'b0, exp_valid = 1'b0, exp_rel = 1'b0;
    int          m_cyc = 0, m_run = 0, m_rel = 0;
    bit          m_held = 1'b0;
    logic [3:0]  m_cand = 4'h0;
    logic [15:0] m_h1 = '0, m_h2 = '0, m_keys = '0;
    logic [11:0] obs, exp_vec;

    assign obs     = {col_n, key, key_down, key_valid, key_release};
    assign exp_vec = {exp_col, exp_key, exp_down, exp_valid, exp_rel};

    task automatic model_step();
        logic [15:0] seen;
        logic [3:0]  code;
        int          c, n;
        bit          ok;
        exp_valid = 1'b0;
        exp_rel   = 1'b0;
        seen = m_h2;
        m_h2 = m_h1;
        m_h1 = mask;
        if (rst) begin
            exp_col = 4'hE; exp_key = 4'h0; exp_down = 1'b0;
            m_cyc = 0; m_run = 0; m_rel = 0; m_held = 1'b0;
        end else if (!en) begin
            exp_col = 4'hF; exp_down = 1'b0;
            m_cyc = 0; m_run = 0; m_rel = 0; m_held = 1'b0;
        end else begin
            if (m_cyc % P == P - 1) begin
                c = (m_cyc / P) % 4;
                for (int r = 0; r < 4; r++) m_keys[r*4 + c] = seen[r*4 + c];
                if (c == 3) begin
                    n = 0; code = 4'h0;
                    for (int k = 0; k < 16; k++) if (m_keys[k]) begin n++; code = 4'(k); end
                    ok = (n == 1);
                    if (!m_held) begin
                        if (m_run > 0 && !(ok && code == m_cand)) m_run = 0;
                        else if (m_run > 0) m_run++;
                        else if (ok) begin m_cand = code; m_run = 1; end
                        if (m_run == DEB) begin
                            m_held = 1'b1; m_run = 0;
                            exp_key = m_cand; exp_down = 1'b1; exp_valid = 1'b1;
                        end
                    end else begin
                        if (ok && code == exp_key) m_rel = 0;
                        else m_rel++;
                        if (m_rel == DEB) begin
                            m_held = 1'b0; m_rel = 0;
                            exp_down = 1'b0; exp_rel = 1'b1;
                        end
                    end
                end
            end
            m_cyc++;
            exp_col = ~(4'b0001 << ((m_cyc / P) % 4));
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic apply_reset();
        rst = 1'b1; en = 1'b1; mask = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] want;
        rst = 1'b1; en = 1'b1; mask = '0;
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (col_n !== 4'hE) begin n_fail++; $display("FAIL reset_col_n got=%h want=e", col_n); end
        n_tests++; if (key !== 4'h0) begin n_fail++; $display("FAIL reset_key got=%h want=0", key); end
        n_tests++; if (key_down !== 1'b0) begin n_fail++; $display("FAIL reset_key_down got=%b want=0", key_down); end
        n_tests++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid got=%b want=0", key_valid); end
        n_tests++; if (key_release !== 1'b0) begin n_fail++; $display("FAIL reset_key_release got=%b want=0", key_release); end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            want = ~(4'b0001 << ((i / P) % 4));
            n_tests++;
            if (col_n !== want) begin n_fail++; $display("FAIL col_sequence cyc=%0d got=%b want=%b", i, col_n, want); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_press_release();
        int nv = 0, nr = 0, v1 = -1, r1 = -1;
        logic [3:0] vkey = 4'h0;
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            // Released just after column 1 of sweep 6 has been sampled.
            mask = (i < 104) ? K9 : 16'h0;
            @(negedge clk);
            n_tests++;
            if (obs !== exp_vec) begin n_fail++; $display("FAIL press_release_cycle cyc=%0d got=%h want=%h", i, obs, exp_vec); end
            if (key_valid === 1'b1) begin nv++; if (nv == 1) begin v1 = i; vkey = key; end end
            if (key_release === 1'b1) begin nr++; if (nr == 1) r1 = i; end
            @(posedge clk);
            #1;
        end
        n_tests++; if (nv != 1) begin n_fail++; $display("FAIL press_valid_count got=%0d want=1", nv); end
        n_tests++; if (v1 != DEB * 4 * P) begin n_fail++; $display("FAIL press_valid_cycle got=%0d want=%0d", v1, DEB * 4 * P); end
        n_tests++; if (vkey !== 4'h9) begin n_fail++; $display("FAIL press_key got=%h want=9", vkey); end
        n_tests++; if (nr != 1) begin n_fail++; $display("FAIL release_count got=%0d want=1", nr); end
        n_tests++; if (r1 != 160) begin n_fail++; $display("FAIL release_cycle got=%0d want=160", r1); end
        n_tests++; if (key !== 4'h9) begin n_fail++; $display("FAIL key_kept_after_release got=%h want=9", key); end
        n_tests++; if (key_down !== 1'b0) begin n_fail++; $display("FAIL key_down_after_release got=%b want=0", key_down); end
    endtask

    task automatic test_bounce();
        int nv = 0, nr = 0, v1 = -1;
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            mask = (i >= 64 || ((i / 10) % 2 == 0)) ? K9 : 16'h0;
            @(negedge clk);
            n_tests++;
            if (obs !== exp_vec) begin n_fail++; $display("FAIL bounce_cycle cyc=%0d got=%h want=%h", i, obs, exp_vec); end
            if (key_valid === 1'b1) begin nv++; if (nv == 1) v1 = i; end
            if (key_release === 1'b1) nr++;
            @(posedge clk);
            #1;
        end
        n_tests++; if (nv != 1) begin n_fail++; $display("FAIL bounce_valid_count got=%0d want=1", nv); end
        n_tests++; if (v1 != 112) begin n_fail++; $display("FAIL bounce_valid_cycle got=%0d want=112", v1); end
        n_tests++; if (nr != 0) begin n_fail++; $display("FAIL bounce_release_count got=%0d want=0", nr); end
    endtask

    task automatic test_multi_key_transfer();
        int nv = 0, nr = 0, v1 = -1, v2 = -1, r1 = -1;
        logic [3:0] k1 = 4'h0, k2 = 4'h0;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            mask = (i < 128) ? (K9 | K2) : ((i < 260) ? K9 : K6);
            @(negedge clk);
            n_tests++;
            if (obs !== exp_vec) begin n_fail++; $display("FAIL multi_transfer_cycle cyc=%0d got=%h want=%h", i, obs, exp_vec); end
            if (key_valid === 1'b1) begin
                nv++;
                if (nv == 1) begin v1 = i; k1 = key; end
                if (nv == 2) begin v2 = i; k2 = key; end
            end
            if (key_release === 1'b1) begin nr++; if (nr == 1) r1 = i; end
            @(posedge clk);
            #1;
        end
        n_tests++; if (v1 != 176) begin n_fail++; $display("FAIL multi_first_valid_cycle got=%0d want=176", v1); end
        n_tests++; if (k1 !== 4'h9) begin n_fail++; $display("FAIL transfer_first_key got=%h want=9", k1); end
        n_tests++; if (r1 != 304) begin n_fail++; $display("FAIL transfer_release_cycle got=%0d want=304", r1); end
        n_tests++; if (v2 != 352) begin n_fail++; $display("FAIL transfer_valid_cycle got=%0d want=352", v2); end
        n_tests++; if (k2 !== 4'h6) begin n_fail++; $display("FAIL transfer_second_key got=%h want=6", k2); end
        n_tests++; if (nv != 2 || nr != 1) begin n_fail++; $display("FAIL transfer_pulse_counts got=%0d/%0d want=2/1", nv, nr); end
    endtask

    task automatic test_enable_mid();
        int nv = 0, nr = 0, v2 = -1;
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            mask = K9;
            en   = !(i >= 80 && i < 100);
            @(negedge clk);
            n_tests++;
            if (obs !== exp_vec) begin n_fail++; $display("FAIL enable_cycle cyc=%0d got=%h want=%h", i, obs, exp_vec); end
            if (i == 81) begin
                n_tests++; if (col_n !== 4'hF) begin n_fail++; $display("FAIL disabled_col_n got=%h want=f", col_n); end
                n_tests++; if (key_down !== 1'b0) begin n_fail++; $display("FAIL disabled_key_down got=%b want=0", key_down); end
                n_tests++; if (key !== 4'h9) begin n_fail++; $display("FAIL disabled_key_kept got=%h want=9", key); end
            end
            if (key_valid === 1'b1) begin nv++; if (nv == 2) v2 = i; end
            if (key_release === 1'b1) nr++;
            @(posedge clk);
            #1;
        end
        en = 1'b1;
        n_tests++; if (nr != 0) begin n_fail++; $display("FAIL disable_release_count got=%0d want=0", nr); end
        n_tests++; if (v2 != 148) begin n_fail++; $display("FAIL reenable_valid_cycle got=%0d want=148", v2); end
    endtask

    task automatic test_reset_mid();
        int nv = 0, v1 = -1;
        apply_reset();
        for (int i = 0; i < 120; i++) begin
            mask = K9;
            rst  = (i == 20);
            @(negedge clk);
            n_tests++;
            if (obs !== exp_vec) begin n_fail++; $display("FAIL reset_mid_cycle cyc=%0d got=%h want=%h", i, obs, exp_vec); end
            if (i == 21) begin
                n_tests++; if (col_n !== 4'hE) begin n_fail++; $display("FAIL reset_mid_col_n got=%b want=1110", col_n); end
                n_tests++; if (key_down !== 1'b0) begin n_fail++; $display("FAIL reset_mid_key_down got=%b want=0", key_down); end
            end
            if (key_valid === 1'b1) begin nv++; if (nv == 1) v1 = i; end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        n_tests++; if (nv != 1) begin n_fail++; $display("FAIL reset_mid_valid_count got=%0d want=1", nv); end
        n_tests++; if (v1 != 21 + DEB * 4 * P) begin n_fail++; $display("FAIL reset_mid_valid_cycle got=%0d want=%0d", v1, 21 + DEB * 4 * P); end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_multi_key_transfer();
        test_enable_mid();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
